// File: rtl/frame_fetch_pkg.sv
// Shared types and helpers for the frame line fetch controller.
// State encoding, data width and burst sizing function.
package frame_fetch_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    REQ,
    DATA
  } fetch_state_e;

  function automatic int unsigned burst_len_f(
    input int unsigned burst_max,
    input int unsigned left
  );
    return (left < burst_max) ? left : burst_max;
  endfunction

endpackage

// File: rtl/frame_line_fetch_ctrl_if.sv
// DDR burst-read request and return-data bundle.
// master = fetch controller, slave = DDR read port.
interface frame_line_fetch_ctrl_if #(
  parameter int ADDR_W = 28,
  parameter int LEN_W  = 8
);
  import frame_fetch_pkg::*;

  logic              ddr_rd_req;
  logic [ADDR_W-1:0] ddr_rd_addr;
  logic [LEN_W-1:0]  ddr_rd_len;
  logic              ddr_rd_ack;
  logic              ddr_rdata_vld;
  logic [DATA_W-1:0] ddr_rdata;

  modport master (
    output ddr_rd_req,
    output ddr_rd_addr,
    output ddr_rd_len,
    input  ddr_rd_ack,
    input  ddr_rdata_vld,
    input  ddr_rdata
  );

  modport slave (
    input  ddr_rd_req,
    input  ddr_rd_addr,
    input  ddr_rd_len,
    output ddr_rd_ack,
    output ddr_rdata_vld,
    output ddr_rdata
  );

endinterface

// File: rtl/fetch_addr_gen.sv
// Line/frame position tracker: word address, line index
// and words remaining in the current line.
module fetch_addr_gen #(
  parameter int ADDR_W      = 28,
  parameter int LEN_W       = 8,
  parameter int LINE_WORDS  = 960,
  parameter int FRAME_LINES = 1080,
  parameter int BASE_ADDR   = 0,
  parameter int WL_W        = 10,
  parameter int LC_W        = 11
) (
  input  logic              wr_clk,
  input  logic              wr_rst_n,
  input  logic              rewind,
  input  logic              load,
  input  logic              advance,
  input  logic              line_end,
  input  logic [LEN_W-1:0]  adv_len,
  output logic [ADDR_W-1:0] addr,
  output logic [WL_W-1:0]   words_left,
  output logic              last_line
);

  localparam logic [ADDR_W-1:0] BASE =
    ADDR_W'(BASE_ADDR);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LC_W-1:0]   line_cnt_q, line_cnt_d;
  logic [WL_W-1:0]   left_q, left_d;

  assign last_line =
    (line_cnt_q == LC_W'(FRAME_LINES - 1));

  always_comb begin
    addr_d     = addr_q;
    line_cnt_d = line_cnt_q;
    left_d     = left_q;
    if (rewind) begin
      addr_d     = BASE;
      line_cnt_d = '0;
    end
    if (load) begin
      left_d = WL_W'(LINE_WORDS);
    end
    if (advance) begin
      addr_d = addr_q + ADDR_W'(adv_len);
      left_d = left_q - WL_W'(adv_len);
    end
    // end of the last line wraps back to the frame origin
    if (line_end) begin
      if (last_line) begin
        line_cnt_d = '0;
        addr_d     = BASE;
      end else begin
        line_cnt_d = line_cnt_q + LC_W'(1);
      end
    end
  end

  always_ff @(posedge wr_clk) begin
    if (!wr_rst_n) begin
      addr_q     <= BASE;
      line_cnt_q <= '0;
      left_q     <= '0;
    end else begin
      addr_q     <= addr_d;
      line_cnt_q <= line_cnt_d;
      left_q     <= left_d;
    end
  end

  assign addr       = addr_q;
  assign words_left = left_q;

endmodule

// File: rtl/frame_line_fetch_ctrl.sv
// DDR -> stitching FIFO line fetch sequencer (write-clock domain).
// FETCH_STALL_STAT_EN adds stall_cycles / burst_cnt statistics.
module frame_line_fetch_ctrl
  import frame_fetch_pkg::*;
#(
  parameter int ADDR_W      = 28,
  parameter int LEN_W       = 8,
  parameter int BURST_LEN   = 64,
  parameter int LINE_WORDS  = 960,
  parameter int FRAME_LINES = 1080,
  parameter int BASE_ADDR   = 0,
  parameter int FIFO_DEPTH  = 2048,
  parameter int LEVEL_W     = 12
) (
  input  logic               wr_clk,
  input  logic               wr_rst_n,
  input  logic               frame_start,
  input  logic               line_start,
  input  logic [LEVEL_W:0]   fifo_wr_level,
  input  logic               fifo_wr_ready,
  frame_line_fetch_ctrl_if.master ddr,
  output logic               fifo_wr_en,
  output logic [DATA_W-1:0]  fifo_wr_data,
  output logic               busy,
  output logic               line_done,
  output logic               frame_done,
  output logic               err_ovf,
  output logic               err_sync
`ifdef FETCH_STALL_STAT_EN
  ,
  output logic [23:0]        stall_cycles,
  output logic [15:0]        burst_cnt
`endif
);

  localparam int WL_W   = $clog2(LINE_WORDS + 1);
  localparam int LC_W   =
    (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
  localparam int FILL_W = LEVEL_W + 2;

  fetch_state_e state_q, state_d;

  logic [LEN_W-1:0]  rcv_q, rcv_d;
  logic              wr_en_q, wr_en_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              line_done_q, line_done_d;
  logic              frame_done_q, frame_done_d;
  logic              err_ovf_q, err_ovf_d;
  logic              err_sync_q, err_sync_d;

  logic              rewind, load, advance, line_end;
  logic [ADDR_W-1:0] addr;
  logic [WL_W-1:0]   words_left;
  logic              last_line;
  logic [LEN_W-1:0]  len;
  logic [FILL_W-1:0] fill_sum;
  logic              fits;
  logic              req;
  logic              fwd;

  fetch_addr_gen #(
    .ADDR_W      (ADDR_W),
    .LEN_W       (LEN_W),
    .LINE_WORDS  (LINE_WORDS),
    .FRAME_LINES (FRAME_LINES),
    .BASE_ADDR   (BASE_ADDR),
    .WL_W        (WL_W),
    .LC_W        (LC_W)
  ) u_addr_gen (
    .wr_clk     (wr_clk),
    .wr_rst_n   (wr_rst_n),
    .rewind     (rewind),
    .load       (load),
    .advance    (advance),
    .line_end   (line_end),
    .adv_len    (len),
    .addr       (addr),
    .words_left (words_left),
    .last_line  (last_line)
  );

  assign len = LEN_W'(burst_len_f(
    BURST_LEN, 32'(words_left)));

  // widened sum so a full FIFO plus a burst cannot wrap
  assign fill_sum = FILL_W'(fifo_wr_level)
                  + FILL_W'(len);
  assign fits = (fill_sum <= FILL_W'(FIFO_DEPTH));

  assign req = (state_q == REQ);
  assign fwd = ddr.ddr_rdata_vld
             && (state_q == DATA);

  always_comb begin
    state_d      = state_q;
    rcv_d        = rcv_q;
    rewind       = 1'b0;
    load         = 1'b0;
    advance      = 1'b0;
    line_end     = 1'b0;
    line_done_d  = 1'b0;
    frame_done_d = 1'b0;
    err_sync_d   = err_sync_q;
    err_ovf_d    = err_ovf_q;
    unique case (state_q)
      IDLE: begin
        rewind = frame_start;
        if (line_start) begin
          load    = 1'b1;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (fits) state_d = REQ;
      end
      REQ: begin
        if (ddr.ddr_rd_ack) begin
          advance = 1'b1;
          rcv_d   = len;
          state_d = DATA;
        end
      end
      DATA: begin
        if (ddr.ddr_rdata_vld) begin
          rcv_d = rcv_q - LEN_W'(1);
          if (rcv_q == LEN_W'(1)) begin
            if (words_left != '0) begin
              state_d = CHECK;
            end else begin
              line_end     = 1'b1;
              line_done_d  = 1'b1;
              frame_done_d = last_line;
              state_d      = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if ((state_q != IDLE)
        && (frame_start || line_start))
      err_sync_d = 1'b1;
    if (ddr.ddr_rdata_vld
        && ((state_q != DATA) || !fifo_wr_ready))
      err_ovf_d = 1'b1;
  end

  always_comb begin
    wr_en_d   = fwd;
    wr_data_d = fwd ? ddr.ddr_rdata : wr_data_q;
  end

  always_ff @(posedge wr_clk) begin
    if (!wr_rst_n) begin
      state_q      <= IDLE;
      rcv_q        <= '0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= '0;
      line_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      err_ovf_q    <= 1'b0;
      err_sync_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rcv_q        <= rcv_d;
      wr_en_q      <= wr_en_d;
      wr_data_q    <= wr_data_d;
      line_done_q  <= line_done_d;
      frame_done_q <= frame_done_d;
      err_ovf_q    <= err_ovf_d;
      err_sync_q   <= err_sync_d;
    end
  end

  assign ddr.ddr_rd_req  = req;
  assign ddr.ddr_rd_addr = req ? addr : '0;
  assign ddr.ddr_rd_len  = req ? len : '0;
  assign fifo_wr_en      = wr_en_q;
  assign fifo_wr_data    = wr_data_q;
  assign busy            = (state_q != IDLE);
  assign line_done       = line_done_q;
  assign frame_done      = frame_done_q;
  assign err_ovf         = err_ovf_q;
  assign err_sync        = err_sync_q;

`ifdef FETCH_STALL_STAT_EN
  logic [23:0] stall_q, stall_d;
  logic [15:0] bcnt_q, bcnt_d;

  always_comb begin
    stall_d = stall_q;
    bcnt_d  = bcnt_q;
    if ((state_q == IDLE) && frame_start) begin
      stall_d = '0;
      bcnt_d  = '0;
    end else begin
      if ((state_q == CHECK) && !fits
          && (stall_q != '1))
        stall_d = stall_q + 24'd1;
      if (req && ddr.ddr_rd_ack)
        bcnt_d = bcnt_q + 16'd1;
    end
  end

  always_ff @(posedge wr_clk) begin
    if (!wr_rst_n) begin
      stall_q <= '0;
      bcnt_q  <= '0;
    end else begin
      stall_q <= stall_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign stall_cycles = stall_q;
  assign burst_cnt    = bcnt_q;
`endif

endmodule

// File: tb/tb_frame_line_fetch_ctrl.sv
// Directed bench: full-size line on one instance, short-line /
// two-line-frame instance for stall, ack delay, errors and reset.
module tb_frame_line_fetch_ctrl;

  typedef struct {
    logic [27:0] addr;
    logic [7:0]  len;
  } req_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   chk  = 0;
  int   errs = 0;

  logic        a_fs, a_ls, a_ready;
  logic [12:0] a_level;
  logic        a_en, a_busy, a_ld, a_fd;
  logic        a_ovf, a_sync;
  logic [31:0] a_data;

  logic        b_fs, b_ls, b_ready;
  logic [12:0] b_level;
  logic        b_en, b_busy, b_ld, b_fd;
  logic        b_ovf, b_sync;
  logic [31:0] b_data;

`ifdef FETCH_STALL_STAT_EN
  logic [23:0] a_stall, b_stall;
  logic [15:0] a_bcnt, b_bcnt;
`endif

  frame_line_fetch_ctrl_if #(
    .ADDR_W(28), .LEN_W(8)) a_if ();
  frame_line_fetch_ctrl_if #(
    .ADDR_W(28), .LEN_W(8)) b_if ();

  frame_line_fetch_ctrl u_a (
    .wr_clk        (clk),
    .wr_rst_n      (rst_n),
    .frame_start   (a_fs),
    .line_start    (a_ls),
    .fifo_wr_level (a_level),
    .fifo_wr_ready (a_ready),
    .ddr           (a_if),
    .fifo_wr_en    (a_en),
    .fifo_wr_data  (a_data),
    .busy          (a_busy),
    .line_done     (a_ld),
    .frame_done    (a_fd),
    .err_ovf       (a_ovf),
    .err_sync      (a_sync)
`ifdef FETCH_STALL_STAT_EN
    ,
    .stall_cycles  (a_stall),
    .burst_cnt     (a_bcnt)
`endif
  );

  frame_line_fetch_ctrl #(
    .LINE_WORDS  (100),
    .FRAME_LINES (2)
  ) u_b (
    .wr_clk        (clk),
    .wr_rst_n      (rst_n),
    .frame_start   (b_fs),
    .line_start    (b_ls),
    .fifo_wr_level (b_level),
    .fifo_wr_ready (b_ready),
    .ddr           (b_if),
    .fifo_wr_en    (b_en),
    .fifo_wr_data  (b_data),
    .busy          (b_busy),
    .line_done     (b_ld),
    .frame_done    (b_fd),
    .err_ovf       (b_ovf),
    .err_sync      (b_sync)
`ifdef FETCH_STALL_STAT_EN
    ,
    .stall_cycles  (b_stall),
    .burst_cnt     (b_bcnt)
`endif
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    chk++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h",
             tag, got, exp);
    end
  endtask

  // scoreboards
  req_t        aq[$], bq[$];
  logic [31:0] ad[$], bd[$];
  req_t        a_r, b_r;
  logic [31:0] a_word, b_word;
  int a_stream = 0, a_req_cnt = 0;
  int a_wr_cnt = 0, a_ld_cnt = 0;
  int b_stream = 0, b_req_cnt = 0;
  int b_wr_cnt = 0, b_ld_cnt = 0;
  int b_fd_cnt = 0, b_wr_at_done = 0;
  int b_wait = 0, b_ack_dly = 0;
  logic        b_prev_ack = 1'b0;
  logic        b_prev_vld = 1'b0;
  logic [27:0] b_cap_a;
  logic [7:0]  b_cap_l;

  always @(negedge clk) begin
    if (a_en) begin
      a_wr_cnt++;
      check("a_dq_nonempty",
            64'(ad.size() != 0), 64'd1);
      if (ad.size() != 0)
        check("a_data", 64'(a_data),
              64'(ad.pop_front()));
    end
    if (a_ld) a_ld_cnt++;
    a_if.ddr_rd_ack    = 1'b0;
    a_if.ddr_rdata_vld = 1'b0;
    if (!rst_n) begin
      a_stream = 0;
    end else if (a_stream > 0) begin
      a_word = $urandom();
      a_if.ddr_rdata_vld = 1'b1;
      a_if.ddr_rdata     = a_word;
      ad.push_back(a_word);
      a_stream--;
    end else if (a_if.ddr_rd_req) begin
      a_if.ddr_rd_ack = 1'b1;
      a_req_cnt++;
      a_stream = int'(a_if.ddr_rd_len);
      check("a_rq_nonempty",
            64'(aq.size() != 0), 64'd1);
      if (aq.size() != 0) begin
        a_r = aq.pop_front();
        check("a_addr", 64'(a_if.ddr_rd_addr),
              64'(a_r.addr));
        check("a_len", 64'(a_if.ddr_rd_len),
              64'(a_r.len));
      end
    end
  end

  always @(negedge clk) begin
    if (b_en) begin
      b_wr_cnt++;
      check("b_dq_nonempty",
            64'(bd.size() != 0), 64'd1);
      if (bd.size() != 0)
        check("b_data", 64'(b_data),
              64'(bd.pop_front()));
    end
    if (rst_n && (b_en || b_prev_vld))
      check("b_wr_latency", 64'(b_en),
            64'(b_prev_vld));
    if (b_ld) begin
      b_ld_cnt++;
      b_wr_at_done = b_wr_cnt;
    end
    if (b_fd) begin
      b_fd_cnt++;
      check("b_fd_with_ld", 64'(b_ld), 64'd1);
    end
    if (b_prev_ack)
      check("b_req_drop",
            64'(b_if.ddr_rd_req), 64'd0);
    b_prev_ack = 1'b0;
    b_if.ddr_rd_ack    = 1'b0;
    b_if.ddr_rdata_vld = 1'b0;
    if (!rst_n) begin
      b_stream = 0;
      b_wait   = 0;
    end else if (b_stream > 0) begin
      b_word = $urandom();
      b_if.ddr_rdata_vld = 1'b1;
      b_if.ddr_rdata     = b_word;
      bd.push_back(b_word);
      b_stream--;
    end else if (b_if.ddr_rd_req) begin
      if (b_wait == 0) begin
        b_cap_a = b_if.ddr_rd_addr;
        b_cap_l = b_if.ddr_rd_len;
      end else begin
        check("b_addr_hold",
              64'(b_if.ddr_rd_addr), 64'(b_cap_a));
        check("b_len_hold",
              64'(b_if.ddr_rd_len), 64'(b_cap_l));
      end
      if (b_wait >= b_ack_dly) begin
        b_if.ddr_rd_ack = 1'b1;
        b_prev_ack = 1'b1;
        b_req_cnt++;
        b_wait = 0;
        b_stream = int'(b_if.ddr_rd_len);
        check("b_rq_nonempty",
              64'(bq.size() != 0), 64'd1);
        if (bq.size() != 0) begin
          b_r = bq.pop_front();
          check("b_addr", 64'(b_if.ddr_rd_addr),
                64'(b_r.addr));
          check("b_len", 64'(b_if.ddr_rd_len),
                64'(b_r.len));
        end
      end else begin
        b_wait++;
      end
    end
    b_prev_vld = b_if.ddr_rdata_vld;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_b_ls();
    b_ls = 1'b1;
    @(negedge clk);
    b_ls = 1'b0;
  endtask

  task automatic push_b_line(input logic [27:0] base);
    bq.push_back('{base, 8'd64});
    bq.push_back('{base + 28'd64, 8'd36});
  endtask

  initial begin
    rst_n = 1'b0;
    a_fs = 1'b0; a_ls = 1'b0;
    a_level = '0; a_ready = 1'b1;
    b_fs = 1'b0; b_ls = 1'b0;
    b_level = '0; b_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("a_rst_ctl", 64'({a_if.ddr_rd_req, a_en,
          a_busy, a_ld, a_fd, a_ovf, a_sync}), 64'd0);
    check("a_rst_addr", 64'(a_if.ddr_rd_addr), 64'd0);
    check("a_rst_len", 64'(a_if.ddr_rd_len), 64'd0);
    check("a_rst_data", 64'(a_data), 64'd0);
    check("b_rst_ctl", 64'({b_if.ddr_rd_req, b_en,
          b_busy, b_ld, b_fd, b_ovf, b_sync}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // full 960-word line, frame_start + line_start together
    for (int i = 0; i < 15; i++)
      aq.push_back('{28'(i * 64), 8'd64});
    a_fs = 1'b1; a_ls = 1'b1;
    @(negedge clk);
    a_fs = 1'b0; a_ls = 1'b0;
    check("a_busy_start", 64'(a_busy), 64'd1);
    for (int i = 0; i < 3000 && a_ld_cnt < 1; i++)
      @(negedge clk);
    @(negedge clk);
    check("a_line_done_cnt", 64'(a_ld_cnt), 64'd1);
    check("a_wr_cnt", 64'(a_wr_cnt), 64'd960);
    check("a_req_cnt", 64'(a_req_cnt), 64'd15);
    check("a_rq_left", 64'(aq.size()), 64'd0);
    check("a_busy_end", 64'(a_busy), 64'd0);
    check("a_errs", 64'({a_ovf, a_sync}), 64'd0);
`ifdef FETCH_STALL_STAT_EN
    check("a_burst_cnt", 64'(a_bcnt), 64'd15);
    check("a_stall", 64'(a_stall), 64'd0);
`endif

    // short line: 64 + 36
    push_b_line(28'd0);
    pulse_b_ls();
    for (int i = 0; i < 500 && b_ld_cnt < 1; i++)
      @(negedge clk);
    @(negedge clk);
    check("b_l0_done", 64'(b_ld_cnt), 64'd1);
    check("b_l0_wr_at_done", 64'(b_wr_at_done), 64'd100);
    check("b_l0_req_cnt", 64'(b_req_cnt), 64'd2);
    check("b_l0_fd", 64'(b_fd_cnt), 64'd0);

    // stall on full FIFO, then delayed ack; last line of frame
    b_level = 13'd2000;
    b_ack_dly = 5;
    push_b_line(28'd100);
    pulse_b_ls();
    repeat (8) @(negedge clk);
    check("b_stall_no_req", 64'(b_if.ddr_rd_req), 64'd0);
    check("b_stall_busy", 64'(b_busy), 64'd1);
    check("b_stall_req_cnt", 64'(b_req_cnt), 64'd2);
`ifdef FETCH_STALL_STAT_EN
    check("b_stall_cnt", 64'(b_stall != 0), 64'd1);
`endif
    b_level = 13'd1984;
    @(negedge clk);
    check("b_unstall_req", 64'(b_if.ddr_rd_req), 64'd1);
    check("b_unstall_addr",
          64'(b_if.ddr_rd_addr), 64'd100);
    for (int i = 0; i < 600 && b_ld_cnt < 2; i++)
      @(negedge clk);
    @(negedge clk);
    b_ack_dly = 0;
    b_level = '0;
    check("b_l1_done", 64'(b_ld_cnt), 64'd2);
    check("b_l1_wr", 64'(b_wr_cnt), 64'd200);
    check("b_l1_fd", 64'(b_fd_cnt), 64'd1);
    check("b_l1_errs", 64'({b_ovf, b_sync}), 64'd0);
`ifdef FETCH_STALL_STAT_EN
    check("b_burst_cnt", 64'(b_bcnt), 64'd4);
`endif

    // new frame restarts at base; inject sync and overflow errors
    push_b_line(28'd0);
    pulse_b_ls();
    for (int i = 0; i < 200 && b_wr_cnt < 210; i++)
      @(negedge clk);
    pulse_b_ls();
    check("b_err_sync", 64'(b_sync), 64'd1);
    b_ready = 1'b0;
    @(negedge clk);
    b_ready = 1'b1;
    @(negedge clk);
    check("b_err_ovf", 64'(b_ovf), 64'd1);
    for (int i = 0; i < 500 && b_ld_cnt < 3; i++)
      @(negedge clk);
    @(negedge clk);
    check("b_l2_done", 64'(b_ld_cnt), 64'd3);
    check("b_l2_wr", 64'(b_wr_cnt), 64'd300);
    check("b_l2_req_cnt", 64'(b_req_cnt), 64'd6);
    check("b_l2_rq_left", 64'(bq.size()), 64'd0);
    check("b_l2_fd", 64'(b_fd_cnt), 64'd1);

    // reset in the middle of a burst
    push_b_line(28'd100);
    pulse_b_ls();
    for (int i = 0; i < 200 && b_wr_cnt < 310; i++)
      @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("b_mrst_ctl", 64'({b_if.ddr_rd_req, b_en,
          b_busy, b_ld, b_fd, b_ovf, b_sync}), 64'd0);
    check("b_mrst_addr", 64'(b_if.ddr_rd_addr), 64'd0);
    check("b_mrst_len", 64'(b_if.ddr_rd_len), 64'd0);
    check("b_mrst_data", 64'(b_data), 64'd0);
`ifdef FETCH_STALL_STAT_EN
    check("b_mrst_bcnt", 64'(b_bcnt), 64'd0);
`endif
    repeat (2) @(negedge clk);
    bq.delete();
    bd.delete();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // after reset the next line starts from base again
    push_b_line(28'd0);
    pulse_b_ls();
    for (int i = 0; i < 500 && b_ld_cnt < 4; i++)
      @(negedge clk);
    @(negedge clk);
    check("b_l4_done", 64'(b_ld_cnt), 64'd4);
    check("b_l4_rq_left", 64'(bq.size()), 64'd0);
    check("b_l4_dq_left", 64'(bd.size()), 64'd0);
    check("b_l4_errs", 64'({b_ovf, b_sync}), 64'd0);
    check("b_l4_busy", 64'(b_busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             chk, errs);
    $finish;
  end

endmodule
